uart_rx_deserializer: RTL and testbench

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

---
 rtl/uart_rx_deserializer.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// UART receive deserializer. Each frame is a start bit, DATA_WIDTH data bits
// sent LSB first, an optional parity bit and a stop bit. Every bit is decided
// by a 2-of-3 majority vote taken around the middle of the bit period.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the PARITY
// state and par_err are built in. When it is undefined, par_err is tied low
// and par_typ is ignored.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [5:0]            p_reg;      // prescale held for the whole frame
  logic [5:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  s0;         // first vote sample of the current bit
  logic                  s1;         // second vote sample of the current bit
  logic                  stop_bit;
  logic [5:0]            p_sel;
  logic [5:0]            half;
  logic [5:0]            samp_lo;
  logic [5:0]            samp_mid;
  logic [5:0]            samp_hi;
  logic [5:0]            cnt_last;
  logic                  cnt_end;
  logic                  maj;

  // Fold the prescale input onto the three supported rates; anything odd runs at 8
  always_comb begin
    p_sel = 6'd8;
    case (prescale)
      6'd16:   p_sel = 6'd16;
      6'd32:   p_sel = 6'd32;
      default: p_sel = 6'd8;
    endcase
  end

  assign half     = {1'b0, p_reg[5:1]};
  assign samp_lo  = half - 6'd1;
  assign samp_mid = half;
  assign samp_hi  = half + 6'd1;
  assign cnt_last = p_reg - 6'd1;
  assign cnt_end  = (edge_cnt == cnt_last);
  // The third sample is the live line, so the vote resolves at samp_hi
  assign maj      = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_exp;
  assign par_exp = (^shift_reg) ^ par_typ;
`else
  logic unused_par_typ;
  assign unused_par_typ = par_typ;
  assign par_err        = 1'b0;
`endif

  // Receive FSM, bit timing, voting and the registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      p_reg      <= 6'd8;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      stop_bit   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      stp_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      par_err    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      stp_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
      if (state != IDLE) begin
        edge_cnt <= cnt_end ? 6'd0 : edge_cnt + 6'd1;
        if (edge_cnt == samp_lo)  s0 <= rx_in;
        if (edge_cnt == samp_mid) s1 <= rx_in;
      end

      case (state)
        IDLE: begin
          if (!rx_in) begin
            state    <= START;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            p_reg    <= p_sel;
          end
        end

        START: begin
          if (edge_cnt == samp_hi && maj) begin
            // Line went back high: treat it as noise and wait for a real start
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (cnt_end) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (edge_cnt == samp_hi) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (bit_cnt == BW'(i)) shift_reg[i] <= maj;
            end
          end
          if (cnt_end) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (edge_cnt == samp_hi) par_bad <= (maj != par_exp);
          if (cnt_end) state <= STOP;
        end
`endif

        STOP: begin
          if (edge_cnt == samp_hi) stop_bit <= maj;
          if (cnt_end) begin
            state   <= IDLE;
            stp_err <= ~stop_bit;
`ifdef UART_RX_PARITY_EN
            par_err <= par_bad;
            if (stop_bit && !par_bad) begin
`else
            if (stop_bit) begin
`endif
              p_data     <= shift_reg;
              data_valid <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
// Scoreboard bench: each frame sent pushes its expected outcome, and the
// monitor pops and compares an entry on every output pulse. The bench follows
// the UART_RX_PARITY_EN macro, so it sends a parity bit only when the
// parity build is selected.
module tb_uart_rx_deserializer;

  localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic [5:0]    prescale = 6'd8;
  logic          par_typ = 1'b0;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_deserializer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pval(input logic [5:0] ps);
    if (ps == 6'd16) return 16;
    if (ps == 6'd32) return 32;
    return 8;
  endfunction

  // Drive one bit period starting on a negedge; optionally flip the middle vote sample
  task automatic drive_bit(input logic b, input int p, input bit corrupt);
    for (int j = 0; j < p; j++) begin
      rx_in = (corrupt && j == p / 2 + 1) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // extra: 1 when the start bit directly follows the previous frame's stop bit
  task automatic send_frame(input logic [7:0] d, input logic [5:0] ps, input logic ptyp,
                            input bit bad_par, input logic stop, input bit corrupt,
                            input int extra, input bit shake_p);
    int   p;
    logic pbit;
    exp_t e;
    p        = pval(ps);
    prescale = ps;
    par_typ  = ptyp;
    pbit     = (^d) ^ ptyp;
    if (bad_par) pbit = ~pbit;
    e.pe = (PAR == 1) && bad_par;
    e.se = !stop;
    e.dv = !e.pe && !e.se;
    if (e.dv) last_good = d;
    e.data = last_good;
    e.at   = cyc + 1 + (2 + DW + PAR) * p + extra;
    sb.push_back(e);
    $display("send data=%02h prescale=%0d par_typ=%0b bad_par=%0b stop=%0b corrupt=%0b",
             d, ps, ptyp, bad_par, stop, corrupt);
    drive_bit(1'b0, p, 1'b0);
    if (shake_p) prescale = (ps == 6'd16) ? 6'd32 : 6'd16;
    for (int i = 0; i < DW; i++) drive_bit(d[i], p, corrupt);
    if (PAR == 1) drive_bit(pbit, p, 1'b0);
    drive_bit(stop, p, 1'b0);
    prescale = ps;
  endtask

  // Monitor: every output pulse consumes one scoreboard entry
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (data_valid || par_err || stp_err)) begin
        $display("rx cyc=%0d dv=%0b pe=%0b se=%0b p_data=%02h",
                 cyc, data_valid, par_err, stp_err, p_data);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("data_valid", {31'd0, data_valid}, {31'd0, e.dv});
          chk("par_err", {31'd0, par_err}, {31'd0, e.pe});
          chk("stp_err", {31'd0, stp_err}, {31'd0, e.se});
          chk("p_data", {24'd0, p_data}, {24'd0, e.data});
          chk("latency", cyc, e.at);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] rd;
    logic [7:0] ab;
    logic [5:0] ps;
    repeat (3) @(negedge clk);
    chk("rst_p_data", {24'd0, p_data}, 32'd0);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_pe", {31'd0, par_err}, 32'd0);
    chk("rst_se", {31'd0, stp_err}, 32'd0);
    rst = 1'b0;
    idle(4);

    // Good frame at prescale 8
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(10);

    // Short low glitch is rejected
    prescale = 6'd16;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    chk("glitch_p_data", {24'd0, p_data}, {24'd0, last_good});

    // Odd parity with a wrong parity bit
    send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    idle(20);
    chk("after_par_p_data", {24'd0, p_data}, {24'd0, last_good});

    // Bad stop bit, then a good frame with no idle gap
    send_frame(8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h7E, 6'd32, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    idle(40);

    // Unsupported prescale runs at 8; a mid-frame prescale change is ignored
    send_frame(8'hC3, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    idle(12);

    // One corrupted vote sample in every data bit
    send_frame(8'h96, 6'd8, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    idle(12);

    // Parity and stop errors together
    send_frame(8'h0F, 6'd8, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(12);

    // Random frames across the legal rates
    for (int k = 0; k < 5; k++) begin
      rd = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       ps = 6'd8;
        1:       ps = 6'd16;
        default: ps = 6'd32;
      endcase
      send_frame(rd, ps, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 1'b1, 1'($urandom_range(0, 1)), 0, 1'b0);
      idle(8);
    end

    // Reset in the middle of data bit 4
    prescale = 6'd8;
    ab = 8'hE7;
    drive_bit(1'b0, 8, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(ab[i], 8, 1'b0);
    rx_in = ab[4];
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_p_data", {24'd0, p_data}, 32'd0);
    chk("midrst_dv", {31'd0, data_valid}, 32'd0);
    chk("midrst_pe", {31'd0, par_err}, 32'd0);
    chk("midrst_se", {31'd0, stp_err}, 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_hold_p_data", {24'd0, p_data}, 32'd0);
    last_good = 8'h00;
    rx_in = 1'b1;
    rst = 1'b0;
    idle(3);
    send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(20);
    chk("final_p_data", {24'd0, p_data}, 32'h55);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
